// File: rtl/alu_multiciclo.sv
// alu_multiciclo: multi-cycle execute-stage ALU with a start/done handshake.
// Single-cycle ops (NOT, AND, OR, XOR, NEG, ADD, SUB, NOP, HLT) take two
// cycles. MUL is shift-add and DIV/MOD is restoring division; each runs
// BITS_DATA iterations. All results and flags are registered. Unsupported
// opcodes and division by zero are reported explicitly instead of producing X.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; aborts any operation in flight
//   start        request, sampled only while busy=0
//   opcode       operation, captured with start
//   operando_a   first operand, captured with start
//   operando_b   second operand, captured with start
//   busy         high while an operation is executing (low in IDLE and FIN)
//   done         one-cycle pulse; resultado and flags are valid from here on
//   resultado    result, held until the next done
//   C/S/O/Z      carry-borrow / sign / overflow-or-truncation / zero
//   div_cero     DIV or MOD with operando_b == 0
//   op_invalido  unsupported opcode
module alu_multiciclo #(
  parameter int BITS_DATA   = 32,
  parameter int BITS_OPCODE = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [BITS_OPCODE-1:0] opcode,
  input  logic [BITS_DATA-1:0]   operando_a,
  input  logic [BITS_DATA-1:0]   operando_b,
  output logic                   busy,
  output logic                   done,
  output logic [BITS_DATA-1:0]   resultado,
  output logic                   C,
  output logic                   S,
  output logic                   O,
  output logic                   Z,
  output logic                   div_cero,
  output logic                   op_invalido
);

  localparam int MSB = BITS_DATA - 1;
  localparam int CW  = $clog2(BITS_DATA);

  // Opcode encodings shared with the control unit.
  localparam logic [BITS_OPCODE-1:0] OP_NOP = BITS_OPCODE'(0);
  localparam logic [BITS_OPCODE-1:0] OP_ADD = BITS_OPCODE'(1);
  localparam logic [BITS_OPCODE-1:0] OP_SUB = BITS_OPCODE'(2);
  localparam logic [BITS_OPCODE-1:0] OP_AND = BITS_OPCODE'(3);
  localparam logic [BITS_OPCODE-1:0] OP_OR  = BITS_OPCODE'(4);
  localparam logic [BITS_OPCODE-1:0] OP_XOR = BITS_OPCODE'(5);
  localparam logic [BITS_OPCODE-1:0] OP_NOT = BITS_OPCODE'(6);
  localparam logic [BITS_OPCODE-1:0] OP_NEG = BITS_OPCODE'(7);
  localparam logic [BITS_OPCODE-1:0] OP_MUL = BITS_OPCODE'(8);
  localparam logic [BITS_OPCODE-1:0] OP_DIV = BITS_OPCODE'(9);
  localparam logic [BITS_OPCODE-1:0] OP_MOD = BITS_OPCODE'(10);
  localparam logic [BITS_OPCODE-1:0] OP_HLT = BITS_OPCODE'(11);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EXEC = 3'd1;
  localparam logic [2:0] ST_MUL  = 3'd2;
  localparam logic [2:0] ST_DIV  = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  logic [2:0]             state;
  logic [BITS_OPCODE-1:0] op_q;
  logic [BITS_DATA-1:0]   a_q, b_q;
  logic [2*BITS_DATA-1:0] mcand, prod;
  logic [BITS_DATA-1:0]   mplier, quo, rem;
  logic [CW-1:0]          cnt;
  logic                   accept;
  logic                   last_iter;

  logic [BITS_DATA:0]     sum_ext, diff_ext, trial;
  logic [BITS_DATA-1:0]   res_n;
  logic                   c_n, o_n, dz_n, inv_n;

  // FIN is not busy so the control unit can issue the next op in that cycle.
  assign busy      = (state != ST_IDLE) && (state != ST_FIN);
  assign accept    = start && !busy;
  assign last_iter = (cnt == CW'(BITS_DATA - 1));

  assign sum_ext  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_ext = {1'b0, a_q} - {1'b0, b_q};
  // Restoring-division trial subtract: shift next dividend bit into the
  // remainder; a clear top bit means the divisor fits.
  assign trial    = {rem, quo[MSB]} - {1'b0, b_q};

  // Result formatting from the captured operands and the iterative datapath.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    res_n = '0;
    c_n   = 1'b0;
    o_n   = 1'b0;
    dz_n  = 1'b0;
    inv_n = 1'b0;
    case (op_q)
      OP_NOT: res_n = ~a_q;
      OP_AND: res_n = a_q & b_q;
      OP_OR:  res_n = a_q | b_q;
      OP_XOR: res_n = a_q ^ b_q;
      OP_NEG: begin
        res_n = -a_q;
        o_n   = (a_q == {1'b1, {(BITS_DATA-1){1'b0}}});
      end
      OP_ADD: begin
        res_n = sum_ext[MSB:0];
        c_n   = sum_ext[BITS_DATA];
        o_n   = (a_q[MSB] == b_q[MSB]) && (sum_ext[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        res_n = diff_ext[MSB:0];
        c_n   = diff_ext[BITS_DATA];
        o_n   = (a_q[MSB] != b_q[MSB]) && (diff_ext[MSB] != a_q[MSB]);
      end
      OP_MUL: begin
        res_n = prod[MSB:0];
        o_n   = |prod[2*BITS_DATA-1:BITS_DATA];
      end
      OP_DIV: begin
        dz_n  = (b_q == '0);
        res_n = dz_n ? '1 : quo;
      end
      OP_MOD: begin
        dz_n  = (b_q == '0);
        res_n = dz_n ? a_q : rem;
      end
      OP_NOP, OP_HLT: res_n = '0;
      default: inv_n = 1'b1;
    endcase
  end

  // Control state and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the value from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      done        <= 1'b0;
      resultado   <= '0;
      C           <= 1'b0;
      S           <= 1'b0;
      O           <= 1'b0;
      Z           <= 1'b0;
      div_cero    <= 1'b0;
      op_invalido <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_FIN: begin
          if (state == ST_FIN) begin
            resultado   <= res_n;
            C           <= c_n;
            S           <= res_n[MSB];
            O           <= o_n;
            Z           <= (res_n == '0);
            div_cero    <= dz_n;
            op_invalido <= inv_n;
            done        <= 1'b1;
          end
          state <= ST_IDLE;
          if (start) begin
            if (opcode == OP_MUL)
              state <= ST_MUL;
            else if ((opcode == OP_DIV || opcode == OP_MOD) && operando_b != '0)
              state <= ST_DIV;
            else
              state <= ST_EXEC;
          end
        end
        // Iterative results pass through EXEC so every op is formatted on
        // the same path before FIN.
        ST_MUL, ST_DIV: if (last_iter) state <= ST_EXEC;
        ST_EXEC:        state <= ST_FIN;
        default:        state <= ST_IDLE;
      endcase
    end
  end

  // Operand capture and iterative datapath.
  // NOTE: these registers carry no reset; they are always reloaded on accept
  // before being used, and the control state alone decides what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= opcode;
      a_q    <= operando_a;
      b_q    <= operando_b;
      mcand  <= {{BITS_DATA{1'b0}}, operando_a};
      mplier <= operando_b;
      prod   <= '0;
      quo    <= operando_a;
      rem    <= '0;
      cnt    <= '0;
    end else if (state == ST_MUL) begin
      prod   <= prod + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end else if (state == ST_DIV) begin
      if (!trial[BITS_DATA]) begin
        rem <= trial[MSB:0];
        quo <= {quo[MSB-1:0], 1'b1};
      end else begin
        rem <= {rem[MSB-1:0], quo[MSB]};
        quo <= {quo[MSB-1:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo (BITS_DATA=32). A reference model
// pushes expected result, flags and latency onto a queue when an op is
// issued; a monitor pops and compares on every done pulse.
module tb_alu_multiciclo;

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5;
  localparam logic [4:0] OP_NOT = 5'd6;
  localparam logic [4:0] OP_NEG = 5'd7;
  localparam logic [4:0] OP_MUL = 5'd8;
  localparam logic [4:0] OP_DIV = 5'd9;
  localparam logic [4:0] OP_MOD = 5'd10;
  localparam logic [4:0] OP_HLT = 5'd11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  opcode = '0;
  logic [31:0] operando_a = '0;
  logic [31:0] operando_b = '0;
  logic        busy, done, C, S, O, Z, div_cero, op_invalido;
  logic [31:0] resultado;

  alu_multiciclo #(.BITS_DATA(32), .BITS_OPCODE(5)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .operando_a(operando_a), .operando_b(operando_b),
    .busy(busy), .done(done), .resultado(resultado),
    .C(C), .S(S), .O(O), .Z(Z), .div_cero(div_cero), .op_invalido(op_invalido)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [5:0]  flags;   // {C,S,O,Z,div_cero,op_invalido}
    int unsigned acc;     // cycle index of the accepting edge
    int unsigned lat;     // edges from acceptance to done
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input logic [4:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] w;
    logic [63:0] p;
    logic [31:0] r;
    logic        c, o, dz, inv;
    r = '0; c = 1'b0; o = 1'b0; dz = 1'b0; inv = 1'b0;
    case (op)
      OP_NOT: r = ~a;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NEG: begin r = -a; o = (a == 32'h8000_0000); end
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0]; c = w[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        r = a - b; c = (a < b);
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_MUL: begin
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0]; o = (p[63:32] != 32'd0);
      end
      OP_DIV: if (b == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end else r = a / b;
      OP_MOD: if (b == 0) begin r = a; dz = 1'b1; end else r = a % b;
      OP_NOP, OP_HLT: r = '0;
      default: inv = 1'b1;
    endcase
    e.tag   = tag;
    e.res   = r;
    e.flags = {c, r[31], o, (r == 32'd0), dz, inv};
    e.acc   = 0;
    e.lat   = (op == OP_MUL || ((op == OP_DIV || op == OP_MOD) && b != 0)) ? 34 : 2;
    return e;
  endfunction

  // Monitor: cycle counter plus scoreboard compare on each done pulse.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (done) begin
      done_cnt++;
      check("done_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".res"}, 64'(resultado), 64'(e.res));
        check({e.tag, ".flags"}, 64'({C, S, O, Z, div_cero, op_invalido}), 64'(e.flags));
        check({e.tag, ".latency"}, 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  // Issue one op for a single edge; inputs are scrambled afterwards so a
  // design that fails to capture them is exposed.
  task automatic drive(input string tag, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input bit track);
    exp_t e;
    @(negedge clk);
    start = 1'b1; opcode = op; operando_a = a; operando_b = b;
    if (track) begin
      e = model(tag, op, a, b);
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0; opcode = 5'h1F; operando_a = ~a; operando_b = ~b;
  endtask

  task automatic drain(input string tag);
    int i = 0;
    while (exp_q.size() != 0 && i < 100) begin
      @(posedge clk);
      i++;
    end
    #2;
    check({tag, ".drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run(input string tag, input logic [4:0] op,
                     input logic [31:0] a, input logic [31:0] b);
    drive(tag, op, a, b, 1'b1);
    drain(tag);
  endtask

  initial begin
    int unsigned dc;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset.outs", 64'({busy, done, resultado, C, S, O, Z, div_cero, op_invalido}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // ADD boundaries.
    run("add_ovf",   OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    run("add_carry", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    run("add_ovf2",  OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);

    // Reset during MUL at counter=5: everything clears, no done follows.
    drive("mul_abort", OP_MUL, 32'd7, 32'd9, 1'b0);
    check("abort.busy_before", 64'(busy), 64'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort.outs", 64'({busy, done, resultado, C, S, O, Z, div_cero, op_invalido}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dc = done_cnt;
    repeat (40) @(posedge clk);
    #2;
    check("abort.no_done", 64'(done_cnt - dc), 64'd0);
    run("add_3_4", OP_ADD, 32'd3, 32'd4);

    // SUB boundaries.
    run("sub_borrow", OP_SUB, 32'd5, 32'd7);
    run("sub_ovf",    OP_SUB, 32'h8000_0000, 32'd1);

    // MUL, DIV, MOD and divide by zero.
    run("mul_trunc", OP_MUL, 32'h0001_0000, 32'h0001_0000);
    run("mul_12_11", OP_MUL, 32'd12, 32'd11);
    run("mul_big",   OP_MUL, 32'hDEAD_BEEF, 32'h0000_1234);
    run("div_100_7", OP_DIV, 32'd100, 32'd7);
    run("mod_100_7", OP_MOD, 32'd100, 32'd7);
    run("div_max",   OP_DIV, 32'hFFFF_FFFF, 32'd3);
    run("div_zero",  OP_DIV, 32'd9, 32'd0);
    run("mod_zero",  OP_MOD, 32'd9, 32'd0);

    // Bitwise, NEG, NOP/HLT and an unused opcode.
    run("not",     OP_NOT, 32'h0F0F_0000, 32'd0);
    run("and",     OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
    run("or",      OP_OR,  32'hF000_0000, 32'h0000_000F);
    run("xor",     OP_XOR, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
    run("neg_min", OP_NEG, 32'h8000_0000, 32'd0);
    run("neg_1",   OP_NEG, 32'd1, 32'd0);
    run("nop",     OP_NOP, 32'd5, 32'd6);
    run("hlt",     OP_HLT, 32'd5, 32'd6);
    run("invalid", 5'h1F,  32'd5, 32'd6);

    // start pulsed during a MUL is ignored: exactly one done.
    dc = done_cnt;
    drive("mul_glitch", OP_MUL, 32'd12, 32'd11, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1; opcode = OP_ADD; operando_a = 32'd1; operando_b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    drain("mul_glitch");
    repeat (5) @(posedge clk);
    #2;
    check("glitch.done_count", 64'(done_cnt - dc), 64'd1);

    // Issue in the FIN cycle: busy is low there and the next op is accepted.
    drive("b2b_add", OP_ADD, 32'd1, 32'd2, 1'b1);
    @(posedge clk);
    #1;
    check("fin.busy", 64'(busy), 64'd0);
    drive("b2b_xor", OP_XOR, 32'h0000_00F0, 32'h0000_00FF, 1'b1);
    drain("b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
